// File: rtl/nv_nvdla_bdma_intr_sched.sv
// rtl/nv_nvdla_bdma_intr_sched.sv - BDMA interrupt scheduler
// Counts per-group done pulses and round-robins them into the interrupt FIFO.
module nv_nvdla_bdma_intr_sched #(
   parameter int CNT_W = 4
) (
   input  logic             nvdla_core_clk,
   input  logic             nvdla_core_rstn,
   input  logic             grp0_done,
   input  logic             grp1_done,
   input  logic             grp0_intr_en,
   input  logic             grp1_intr_en,
   output logic             fifo_intr_wr_pvld,
   input  logic             fifo_intr_wr_prdy,
   output logic             fifo_intr_wr_pd,
   input  logic             fifo_intr_wr_idle,
   output logic [CNT_W-1:0] pend_cnt0,
   output logic [CNT_W-1:0] pend_cnt1,
   output logic             ovf_err,
   input  logic             ovf_clr,
   output logic             sched_idle
);

   typedef enum logic {ST_EMPTY = 1'b0, ST_PRESENT = 1'b1} state_t;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic             pd_q, pd_d;
   logic             last_q, last_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;
   logic             inc0, inc1, acc, dec0, dec1;
   logic             sat0, sat1, any_nz, sel;

   assign inc0 = grp0_done & grp0_intr_en;
   assign inc1 = grp1_done & grp1_intr_en;
   assign acc  = (state_q == ST_PRESENT) & fifo_intr_wr_prdy;
   assign dec0 = acc & ~pd_q;
   assign dec1 = acc & pd_q;

   always_comb begin
      cnt0_d = cnt0_q;
      sat0   = 1'b0;
      if (inc0 && !dec0) begin
         if (cnt0_q == CNT_MAX) sat0 = 1'b1;
         else                   cnt0_d = cnt0_q + 1'b1;
      end else if (dec0 && !inc0) begin
         cnt0_d = cnt0_q - 1'b1;
      end
   end

   always_comb begin
      cnt1_d = cnt1_q;
      sat1   = 1'b0;
      if (inc1 && !dec1) begin
         if (cnt1_q == CNT_MAX) sat1 = 1'b1;
         else                   cnt1_d = cnt1_q + 1'b1;
      end else if (dec1 && !inc1) begin
         cnt1_d = cnt1_q - 1'b1;
      end
   end

   // A lost pulse outranks a same-cycle clear.
   always_comb begin
      ovf_d = ovf_q;
      if (sat0 || sat1) ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
   end

   // Selection looks at post-increment, post-accept counts so there is no bubble.
   always_comb begin
      any_nz  = (cnt0_d != '0) || (cnt1_d != '0);
      if ((cnt0_d != '0) && (cnt1_d != '0)) sel = ~last_q;
      else                                  sel = (cnt0_d == '0);
      state_d = state_q;
      pd_d    = pd_q;
      last_d  = last_q;
      if ((state_q == ST_EMPTY) || acc) begin
         if (any_nz) begin
            state_d = ST_PRESENT;
            pd_d    = sel;
            last_d  = sel;
         end else begin
            state_d = ST_EMPTY;
         end
      end
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) begin
         state_q <= ST_EMPTY;
         pd_q    <= 1'b0;
         last_q  <= 1'b1;
         ovf_q   <= 1'b0;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
      end else begin
         state_q <= state_d;
         pd_q    <= pd_d;
         last_q  <= last_d;
         ovf_q   <= ovf_d;
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
      end
   end

   assign fifo_intr_wr_pvld = (state_q == ST_PRESENT);
   assign fifo_intr_wr_pd   = pd_q;
   assign pend_cnt0         = cnt0_q;
   assign pend_cnt1         = cnt1_q;
   assign ovf_err           = ovf_q;
   assign sched_idle        = (cnt0_q == '0) & (cnt1_q == '0) &
                              (state_q == ST_EMPTY) & fifo_intr_wr_idle;

endmodule

// File: tb/tb_nv_nvdla_bdma_intr_sched.sv
// tb/tb_nv_nvdla_bdma_intr_sched.sv - self-checking bench for the BDMA interrupt scheduler
module tb_nv_nvdla_bdma_intr_sched;

   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             g0 = 1'b0, g1 = 1'b0, en0 = 1'b1, en1 = 1'b1;
   logic             prdy = 1'b0, fidle = 1'b1, clr = 1'b0;
   logic             pvld, pd, ovf, idle;
   logic [CNT_W-1:0] cnt0, cnt1;

   int n_cmp = 0;
   int n_err = 0;

   int m_cnt [2] = '{0, 0};
   bit m_pvld = 0, m_pd = 0, m_last = 1, m_ovf = 0;

   always #5 clk = ~clk;

   nv_nvdla_bdma_intr_sched #(.CNT_W(CNT_W)) dut (
      .nvdla_core_clk    (clk),
      .nvdla_core_rstn   (rstn),
      .grp0_done         (g0),
      .grp1_done         (g1),
      .grp0_intr_en      (en0),
      .grp1_intr_en      (en1),
      .fifo_intr_wr_pvld (pvld),
      .fifo_intr_wr_prdy (prdy),
      .fifo_intr_wr_pd   (pd),
      .fifo_intr_wr_idle (fidle),
      .pend_cnt0         (cnt0),
      .pend_cnt1         (cnt1),
      .ovf_err           (ovf),
      .ovf_clr           (clr),
      .sched_idle        (idle)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Event-count view: pending = captured - accepted, clamped at the counter ceiling.
   task automatic model_step();
      bit acc, set;
      int n;
      int nz [$];
      bit done [2];
      bit en [2];
      done = '{g0, g1};
      en   = '{en0, en1};
      if (!rstn) begin
         m_cnt = '{0, 0};
         m_pvld = 0; m_pd = 0; m_last = 1; m_ovf = 0;
         return;
      end
      acc = m_pvld && prdy;
      set = 0;
      for (int g = 0; g < 2; g++) begin
         n = m_cnt[g] + int'(done[g] && en[g]) - int'(acc && (int'(m_pd) == g));
         if (n > CMAX) begin
            n = CMAX;
            set = 1;
         end
         m_cnt[g] = n;
      end
      m_ovf = set ? 1'b1 : (clr ? 1'b0 : m_ovf);
      if (!m_pvld || acc) begin
         for (int g = 0; g < 2; g++) if (m_cnt[g] > 0) nz.push_back(g);
         if (nz.size() == 0) m_pvld = 0;
         else begin
            m_pd = (nz.size() == 2) ? !m_last : bit'(nz[0]);
            m_last = m_pd;
            m_pvld = 1;
         end
      end
   endtask

   task automatic check_all();
      check("pvld", {7'd0, pvld}, {7'd0, m_pvld});
      if (m_pvld) check("pd", {7'd0, pd}, {7'd0, m_pd});
      check("cnt0", {4'd0, cnt0}, 8'(m_cnt[0]));
      check("cnt1", {4'd0, cnt1}, 8'(m_cnt[1]));
      check("ovf", {7'd0, ovf}, {7'd0, m_ovf});
      check("idle", {7'd0, idle},
            {7'd0, (m_cnt[0] == 0) && (m_cnt[1] == 0) && !m_pvld && fidle});
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      cyc();
      rstn = 1'b1;
   endtask

   initial begin
      // reset state
      do_reset();
      cyc();
      check("rst_pvld", {7'd0, pvld}, 8'd0);
      check("rst_cnt0", {4'd0, cnt0}, 8'd0);
      check("rst_cnt1", {4'd0, cnt1}, 8'd0);
      check("rst_ovf", {7'd0, ovf}, 8'd0);
      check("rst_idle", {7'd0, idle}, 8'd1);

      // single event
      prdy = 1'b1; g0 = 1'b1;
      cyc();
      g0 = 1'b0;
      check("single_pvld", {7'd0, pvld}, 8'd1);
      check("single_pd", {7'd0, pd}, 8'd0);
      check("single_cnt", {4'd0, cnt0}, 8'd1);
      check("single_idle_busy", {7'd0, idle}, 8'd0);
      cyc();
      check("single_drain", {7'd0, pvld}, 8'd0);
      check("single_cnt0", {4'd0, cnt0}, 8'd0);
      check("single_idle", {7'd0, idle}, 8'd1);

      // tie and alternation from a fresh last_grant
      do_reset();
      prdy = 1'b0; g0 = 1'b1; g1 = 1'b1;
      repeat (3) cyc();
      g0 = 1'b0; g1 = 1'b0;
      check("tie_cnt0", {4'd0, cnt0}, 8'd3);
      check("tie_cnt1", {4'd0, cnt1}, 8'd3);
      prdy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         check("alt_pvld", {7'd0, pvld}, 8'd1);
         check("alt_pd", {7'd0, pd}, 8'(i % 2));
         cyc();
      end
      check("alt_end", {7'd0, pvld}, 8'd0);

      // backpressure hold
      prdy = 1'b0; g1 = 1'b1;
      cyc();
      g1 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         g0 = (i == 0 || i == 2);
         cyc();
         check("bp_pd", {7'd0, pd}, 8'd1);
      end
      g0 = 1'b0;
      check("bp_cnt0", {4'd0, cnt0}, 8'd2);
      prdy = 1'b1;
      cyc();
      check("bp_next_pd", {7'd0, pd}, 8'd0);
      repeat (3) cyc();

      // saturation
      prdy = 1'b0; g0 = 1'b1;
      repeat (CMAX) cyc();
      check("sat_cnt", {4'd0, cnt0}, 8'(CMAX));
      check("sat_noovf", {7'd0, ovf}, 8'd0);
      cyc();
      check("sat_cnt_hold", {4'd0, cnt0}, 8'(CMAX));
      check("sat_ovf", {7'd0, ovf}, 8'd1);
      g0 = 1'b0; clr = 1'b1;
      cyc();
      clr = 1'b0;
      check("ovf_clr", {7'd0, ovf}, 8'd0);
      g0 = 1'b1; prdy = 1'b1;
      cyc();
      g0 = 1'b0;
      check("sat_incdec_cnt", {4'd0, cnt0}, 8'(CMAX));
      check("sat_incdec_ovf", {7'd0, ovf}, 8'd0);
      repeat (CMAX + 1) cyc();
      check("sat_drain", {4'd0, cnt0}, 8'd0);

      // enable masking
      en1 = 1'b0; prdy = 1'b0; g1 = 1'b1;
      repeat (4) cyc();
      g1 = 1'b0;
      check("mask_cnt1", {4'd0, cnt1}, 8'd0);
      check("mask_pvld", {7'd0, pvld}, 8'd0);
      check("mask_ovf", {7'd0, ovf}, 8'd0);
      en1 = 1'b1; g1 = 1'b1;
      cyc();
      g1 = 1'b0; en1 = 1'b0;
      cyc();
      check("mask_keep_pvld", {7'd0, pvld}, 8'd1);
      check("mask_keep_pd", {7'd0, pd}, 8'd1);
      prdy = 1'b1;
      cyc();
      check("mask_issued", {4'd0, cnt1}, 8'd0);
      en1 = 1'b1;

      // reset mid-stream
      prdy = 1'b0; g0 = 1'b1; g1 = 1'b1;
      repeat (2) cyc();
      g1 = 1'b0;
      repeat (3) cyc();
      g0 = 1'b0;
      check("mid_cnt0", {4'd0, cnt0}, 8'd5);
      check("mid_cnt1", {4'd0, cnt1}, 8'd2);
      do_reset();
      check("mid_rst_pvld", {7'd0, pvld}, 8'd0);
      check("mid_rst_pd", {7'd0, pd}, 8'd0);
      check("mid_rst_cnt", {4'd0, cnt0 | cnt1}, 8'd0);
      check("mid_rst_idle", {7'd0, idle}, 8'd1);
      g0 = 1'b1; g1 = 1'b1;
      cyc();
      g0 = 1'b0; g1 = 1'b0;
      check("mid_tie_pd", {7'd0, pd}, 8'd0);
      prdy = 1'b1;
      repeat (3) cyc();

      // randomized traffic against the event-count model
      for (int i = 0; i < 3000; i++) begin
         g0    = ($urandom_range(0, 2) == 0);
         g1    = ($urandom_range(0, 2) == 0);
         en0   = ($urandom_range(0, 9) != 0);
         en1   = ($urandom_range(0, 9) != 0);
         prdy  = ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 2 : 7));
         clr   = ($urandom_range(0, 19) == 0);
         fidle = ($urandom_range(0, 3) != 0);
         rstn  = ($urandom_range(0, 199) != 0);
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/nv_nvdla_bdma_intr_sched.md
# nv_nvdla_bdma_intr_sched

Interrupt scheduler for the BDMA store path. It collects per-group "operation done" pulses from the two BDMA register groups. It queues them in saturating pending counters and round-robin schedules them into the 1-bit interrupt FIFO over a valid/ready handshake, with the FIFO payload carrying the group id. It also reports idle and overflow status to the BDMA status logic.

## Interface
Parameters:
- CNT_W, 4, width of each per-group pending counter; saturates at 2^CNT_W-1.

Ports:
- nvdla_core_clk  in  1  core clock; single clock domain.
- nvdla_core_rstn  in  1  reset; synchronous, active-low.
- grp0_done  in  1  single-cycle done pulse from register group 0.
- grp1_done  in  1  single-cycle done pulse from register group 1.
- grp0_intr_en  in  1  capture enable for group 0 pulses (config, quasi-static).
- grp1_intr_en  in  1  capture enable for group 1 pulses.
- fifo_intr_wr_pvld  out  1  write valid to interrupt FIFO.
- fifo_intr_wr_prdy  in  1  write ready from interrupt FIFO.
- fifo_intr_wr_pd  out  1  group id of the presented interrupt (0 or 1).
- fifo_intr_wr_idle  in  1  FIFO reports empty and no valid in flight.
- pend_cnt0  out  CNT_W  group 0 events not yet accepted by FIFO.
- pend_cnt1  out  CNT_W  group 1 events not yet accepted by FIFO.
- ovf_err  out  1  sticky flag; set when a pulse is lost to saturation.
- ovf_clr  in  1  clears ovf_err.
- sched_idle  out  1  no pending work anywhere in the interrupt path.

## Operation
- Capture: grpN_done & grpN_intr_en increments pend_cntN. Pulses arriving while disabled are dropped silently and do not set ovf_err.
- Accept: fifo_intr_wr_pvld & fifo_intr_wr_prdy decrements the counter of group fifo_intr_wr_pd.
- Increment and decrement of the same counter in one cycle: counter unchanged, no overflow.
- Saturation: increment while counter = max and no same-cycle decrement leaves the counter at max and sets ovf_err.
- ovf_err: ovf_clr clears it; if a set and a clear occur in the same cycle, set wins.
- Clearing an enable does not flush pending events; already-counted events are still issued.
- Output register states:
  - EMPTY (pvld=0).
  - PRESENT (pvld=1, pd held).
- Transitions:
  - EMPTY→PRESENT when next-state counts (after this cycle's increments) have any nonzero.
  - PRESENT→PRESENT stays with pd and pvld stable while !prdy.
  - On accept, re-select from post-accept next-state counts; if all are zero, go to EMPTY.
- Selection (round-robin):
  - Only one group nonzero: grant that group.
  - Both nonzero: grant the group ≠ last_grant.
  - last_grant updates on every selection. Reset value 1, so group 0 wins the first tie.
- A presented event stays counted until accepted. pend_cntN ≥ 1 whenever pvld=1 & pd=N.
- sched_idle = (pend_cnt0==0) & (pend_cnt1==0) & !fifo_intr_wr_pvld & fifo_intr_wr_idle. This is a combinational output.

## Timing
- Reset values: fifo_intr_wr_pvld=0, fifo_intr_wr_pd=0, pend_cnt0=pend_cnt1=0, ovf_err=0, last_grant=1. With fifo_intr_wr_idle=1, sched_idle=1.
- Reset asserted mid-operation: all state returns to reset values at the next edge; pending events are discarded.
- Latency: done pulse at cycle t with output EMPTY → pvld=1 at t+1.
- Throughput: one accept per cycle while prdy=1 and any count is nonzero; no bubble cycles between accepts.
- Counters update at the clock edge after the pulse or accept.
- ovf_err sets at the edge following the lost pulse.
- pd changes only on an accept or on an EMPTY→PRESENT transition.

## Test plan
- Single event: grp0_done=1 at t with prdy=1 → pvld=1, pd=0 at t+1; accepted at t+1; pend_cnt0 = 1 then 0; pvld=0 at t+2; sched_idle returns to 1.
- Tie and alternation: both groups pulse 3 times with prdy held 0, so counts are 3/3. Release prdy → accepts in pd order 0,1,0,1,0,1 on 6 consecutive cycles, then pvld=0.
- Backpressure hold: pvld=1, pd=1, prdy=0 for 5 cycles while group 0 pulses twice → pd stays 1, pend_cnt0=2; after release the next pd is 0.
- Saturation (CNT_W=4): 15 group-0 pulses with prdy=0 → pend_cnt0=15, ovf_err=0. 16th pulse → count 15, ovf_err=1. Pulse and accept in the same cycle at 15 → count stays 15, no new set. ovf_clr → ovf_err=0.
- Enable masking: grp1_intr_en=0 with 4 pulses → pend_cnt1=0, no pvld. Enable set, 1 pulse, then enable cleared before accept → event is still issued with pd=1.
- Reset mid-stream: counts 5/2 and pvld=1, then assert nvdla_core_rstn=0 for one edge → all outputs at reset values. The first tie after reset grants group 0.
